// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

   // Fetch FSM states.
   typedef enum logic [1:0] {
      FS_IDLE = 2'b00,
      FS_REQ  = 2'b01,
      FS_WAIT = 2'b10
   } fetch_state_e;

   // Fixed AXI read-address attributes: single 8-byte incrementing beat.
   localparam logic [1:0] AR_BURST_INCR = 2'b01;
   localparam logic [2:0] AR_SIZE_8B    = 3'd3;
   localparam logic [7:0] AR_LEN_1      = 8'd0;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   // Fetch-queue entry layout: pc, instruction pair, fault flag.
   localparam int FQ_PC_W    = 32;
   localparam int FQ_DATA_W  = 64;
   localparam int FQ_FAULT_W = 1;
   localparam int FQ_ENTRY_W = FQ_PC_W + FQ_DATA_W + FQ_FAULT_W;

   typedef struct packed {
      logic [FQ_PC_W-1:0]    pc;
      logic [FQ_DATA_W-1:0]  data;
      logic [FQ_FAULT_W-1:0] fault;
   } fq_entry_t;

   // Force an address onto an 8-byte (instruction pair) boundary.
   function automatic logic [31:0] align8(input logic [31:0] addr);
      return {addr[31:3], 3'b000};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous fetch queue of instruction pairs with flush; head fields are
// exposed combinationally and read as all-zero when the queue is empty.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  fq_entry_t                push_entry,
   input  logic                     pop,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     head_valid,
   output fq_entry_t                head_entry
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fq_entry_t          mem_r [DEPTH];
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [CNT_W-1:0]   count_r;
   logic               do_push_s;
   logic               do_pop_s;

   // Qualify push/pop; a flush discards both in the same cycle.
   always_comb begin
      do_push_s = 1'b0;
      do_pop_s  = 1'b0;
      if (flush) begin
         do_push_s = 1'b0;
         do_pop_s  = 1'b0;
      end else begin
         do_push_s = push;
         do_pop_s  = pop && (count_r != CNT_W'(0));
      end
   end

   // Entry storage, written at the tail on push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (do_push_s) begin
         mem_r[wr_ptr_r] <= push_entry;
      end
   end

   // Read/write pointers; power-of-two depth makes the natural wrap modulo DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_r <= PTR_W'(0);
         wr_ptr_r <= PTR_W'(0);
      end else if (flush) begin
         rd_ptr_r <= PTR_W'(0);
         wr_ptr_r <= PTR_W'(0);
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
      end
   end

   // Occupancy count; simultaneous push and pop leave it unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= CNT_W'(0);
      end else if (flush) begin
         count_r <= CNT_W'(0);
      end else begin
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Head presentation: zeros when empty so decode never sees stale data.
   always_comb begin
      head_valid = (count_r != CNT_W'(0));
      head_entry = '0;
      if (head_valid) begin
         head_entry = mem_r[rd_ptr_r];
      end else begin
         head_entry = '0;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, single-outstanding AXI read requests,
// fetch queue towards decode, and redirect/kill handling.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          FQ_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        arvalid,
   output logic [31:0] araddr,
   output logic [1:0]  arburst,
   output logic [2:0]  arsize,
   output logic [7:0]  arlen,
   input  logic        arready,
   output logic        rready,
   input  logic        rvalid,
   input  logic [63:0] rdata,
   input  logic        rlast,
   input  logic [1:0]  rresp,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        dec_valid,
   output logic [31:0] dec_pc,
   output logic [31:0] dec_instr0,
   output logic [31:0] dec_instr1,
   output logic        dec_fault,
   input  logic        dec_ready
);

   localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

   fetch_state_e       state_r;
   fetch_state_e       state_nx_s;
   logic [31:0]        pc_r;
   logic [31:0]        req_pc_r;
   logic [31:0]        araddr_r;
   logic               arvalid_r;
   logic               kill_r;
   logic               kill_nx_s;

   logic [CNT_W-1:0]   fq_count_s;
   logic               credit_s;
   logic               ar_hs_s;
   logic               r_hs_s;
   logic               rready_s;
   logic               push_s;
   logic               pop_s;
   fq_entry_t          push_entry_s;
   fq_entry_t          head_s;
   logic               head_valid_s;
   logic               unused_s;

   // Handshake events and queue control; redirect overrides push and pop.
   always_comb begin
      rready_s     = (state_r == FS_WAIT);
      ar_hs_s      = arvalid_r && arready;
      r_hs_s       = rvalid && rready_s;
      credit_s     = (fq_count_s < CNT_W'(FQ_DEPTH));
      push_s       = r_hs_s && !kill_r && !redirect_valid;
      pop_s        = head_valid_s && dec_ready && !redirect_valid;
      push_entry_s = '{pc: req_pc_r, data: rdata, fault: (rresp != RESP_OKAY)};
   end

   // Next-state logic; a redirect never abandons an address already offered.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         FS_IDLE: begin
            if (credit_s && !redirect_valid) begin
               state_nx_s = FS_REQ;
            end else begin
               state_nx_s = FS_IDLE;
            end
         end
         FS_REQ: begin
            if (ar_hs_s) begin
               state_nx_s = FS_WAIT;
            end else begin
               state_nx_s = FS_REQ;
            end
         end
         FS_WAIT: begin
            if (r_hs_s) begin
               state_nx_s = FS_IDLE;
            end else begin
               state_nx_s = FS_WAIT;
            end
         end
         default: state_nx_s = FS_IDLE;
      endcase
   end

   // Kill tracking: a redirect marks the outstanding request stale unless its
   // response is being accepted (and dropped) in that same cycle.
   always_comb begin
      kill_nx_s = kill_r;
      if (redirect_valid) begin
         if (state_r == FS_REQ) begin
            kill_nx_s = 1'b1;
         end else if (state_r == FS_WAIT) begin
            kill_nx_s = !r_hs_s;
         end else begin
            kill_nx_s = 1'b0;
         end
      end else if (r_hs_s) begin
         kill_nx_s = 1'b0;
      end else begin
         kill_nx_s = kill_r;
      end
   end

   // State, kill flag and the registered read-address channel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= FS_IDLE;
         kill_r    <= 1'b0;
         arvalid_r <= 1'b0;
         araddr_r  <= RESET_PC;
      end else begin
         state_r   <= state_nx_s;
         kill_r    <= kill_nx_s;
         arvalid_r <= (state_nx_s == FS_REQ);
         if ((state_r == FS_IDLE) && (state_nx_s == FS_REQ)) begin
            araddr_r <= pc_r;
         end
      end
   end

   // PC bookkeeping; once a redirect has hit a pending request, pc already
   // holds the new target and must not advance on that stale handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r     <= RESET_PC;
         req_pc_r <= RESET_PC;
      end else begin
         if (ar_hs_s) begin
            req_pc_r <= araddr_r;
         end
         if (redirect_valid) begin
            pc_r <= align8(redirect_pc);
         end else if (ar_hs_s && !kill_r) begin
            pc_r <= pc_r + 32'd8;
         end
      end
   end

   fetch_queue #(
      .DEPTH (FQ_DEPTH)
   ) u_fetch_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (redirect_valid),
      .push       (push_s),
      .push_entry (push_entry_s),
      .pop        (pop_s),
      .count      (fq_count_s),
      .head_valid (head_valid_s),
      .head_entry (head_s)
   );

   assign arvalid    = arvalid_r;
   assign araddr     = araddr_r;
   assign arburst    = AR_BURST_INCR;
   assign arsize     = AR_SIZE_8B;
   assign arlen      = AR_LEN_1;
   assign rready     = rready_s;
   assign dec_valid  = head_valid_s;
   assign dec_pc     = head_s.pc;
   assign dec_instr0 = head_s.data[31:0];
   assign dec_instr1 = head_s.data[63:32];
   assign dec_fault  = head_s.fault[0];

   // rlast carries no information for single-beat reads; low PC bits are discarded.
   assign unused_s = ^{rlast, redirect_pc[2:0]};

endmodule
